// File: rtl/acq_pkg.sv
// Shared definitions for the ADC capture sequencer: FSM state codes,
// packer word geometry and the packer phase helper.
package acq_pkg;

    localparam int ACQ_ADC_W        = 10;
    localparam int SAMPLES_PER_WORD = 3;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_DELAY   = 3'd1;
    localparam state_t S_CAPTURE = 3'd2;
    localparam state_t S_FLUSH   = 3'd3;
    localparam state_t S_DONE    = 3'd4;

    // Position of the next sample inside the packer word, wrapping at 3.
    function automatic logic [1:0] phase_inc(input logic [1:0] p);
        return (p == 2'(SAMPLES_PER_WORD - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/adc_decim_strobe.sv
// Decimation strobe: passes 1 of every (factor+1) input strobes.
// Ports: clk, rst (sync, active-high), restart (hold counter at 0),
//        strobe (sample strobe), factor (N), keep (kept-sample pulse).
module adc_decim_strobe #(
    parameter int DEC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             strobe,
    input  logic [DEC_W-1:0] factor,
    output logic             keep
);

    logic [DEC_W-1:0] cnt;

    // The (factor+1)-th strobe after a restart is the first one kept.
    assign keep = strobe && !restart && (cnt == factor);

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (strobe) begin
            cnt <= (cnt == factor) ? '0 : cnt + DEC_W'(1);
        end
    end

endmodule

// File: rtl/adc_acq_ctrl.sv
// Trigger-driven capture sequencer feeding the 3x10-bit ADC word packer.
// Ports: clk, rst (sync, active-high); i_trig, i_abort pulses;
//        i_cfg_delay/len/decim config (latched on trigger);
//        i_adc_data/i_adc_vld ADC input; i_fifo_afull backpressure hint;
//        o_pack_data/o_pack_vld to packer; o_busy, o_done, o_ovf status.
// Build option: define ACQ_TESTPAT_EN to replace samples with a ramp.
module adc_acq_ctrl
    import acq_pkg::*;
#(
    parameter int ADC_W = ACQ_ADC_W,
    parameter int CNT_W = 16,
    parameter int DEC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_trig,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_cfg_delay,
    input  logic [CNT_W-1:0] i_cfg_len,
    input  logic [DEC_W-1:0] i_cfg_decim,
    input  logic [ADC_W-1:0] i_adc_data,
    input  logic             i_adc_vld,
    input  logic             i_fifo_afull,
    output logic [ADC_W-1:0] o_pack_data,
    output logic             o_pack_vld,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_ovf
);

    state_t           state;
    logic [CNT_W-1:0] dly_cnt;
    logic [CNT_W-1:0] len_cnt;
    logic [DEC_W-1:0] decim;
    logic [1:0]       phase;
    logic [1:0]       phase_nx;
    logic             keep;
    logic [ADC_W-1:0] sample;

    adc_decim_strobe #(
        .DEC_W (DEC_W)
    ) u_decim (
        .clk     (clk),
        .rst     (rst),
        .restart (state != S_CAPTURE),
        .strobe  (i_adc_vld && (state == S_CAPTURE)),
        .factor  (decim),
        .keep    (keep)
    );

    // A dropped sample does not advance the packer phase.
    assign phase_nx = i_fifo_afull ? phase : phase_inc(phase);

`ifdef ACQ_TESTPAT_EN
    logic [ADC_W-1:0] ramp;

    always_ff @(posedge clk) begin
        if (rst) begin
            ramp <= '0;
        end else if (state == S_IDLE && i_trig) begin
            ramp <= '0;
        end else if (keep && !i_abort) begin
            ramp <= ramp + ADC_W'(1);
        end
    end

    assign sample = ramp;
`else
    assign sample = i_adc_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            dly_cnt     <= '0;
            len_cnt     <= '0;
            decim       <= '0;
            phase       <= '0;
            o_pack_data <= '0;
            o_pack_vld  <= 1'b0;
            o_ovf       <= 1'b0;
        end else begin
            o_pack_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_trig) begin
                        dly_cnt <= i_cfg_delay;
                        len_cnt <= i_cfg_len;
                        decim   <= i_cfg_decim;
                        phase   <= '0;
                        o_ovf   <= 1'b0;
                        if (i_cfg_len == '0)
                            state <= S_DONE;
                        else if (i_cfg_delay == '0)
                            state <= S_CAPTURE;
                        else
                            state <= S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (i_abort) begin
                        state <= S_FLUSH;
                    end else if (i_adc_vld) begin
                        dly_cnt <= dly_cnt - CNT_W'(1);
                        if (dly_cnt == CNT_W'(1))
                            state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (i_abort) begin
                        state <= S_FLUSH;
                    end else if (keep) begin
                        len_cnt <= len_cnt - CNT_W'(1);
                        phase   <= phase_nx;
                        if (i_fifo_afull) begin
                            o_ovf <= 1'b1;
                        end else begin
                            o_pack_vld  <= 1'b1;
                            o_pack_data <= sample;
                        end
                        if (len_cnt == CNT_W'(1))
                            state <= (phase_nx == 2'd0) ? S_DONE : S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // Pad with zeros until the packer word is complete.
                    if (phase == 2'd0) begin
                        state <= S_DONE;
                    end else begin
                        o_pack_vld  <= 1'b1;
                        o_pack_data <= '0;
                        phase       <= phase_inc(phase);
                        if (phase_inc(phase) == 2'd0)
                            state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_busy = (state == S_DELAY) || (state == S_CAPTURE) ||
                    (state == S_FLUSH);
    assign o_done = (state == S_DONE);

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// Self-checking bench for adc_acq_ctrl: directed scenarios plus
// randomized captures checked against an event-level reference model.
module tb_adc_acq_ctrl;

    localparam int ADC_W = 10;
    localparam int CNT_W = 16;
    localparam int DEC_W = 4;
    localparam int N     = 400;

    logic             clk;
    logic             rst;
    logic             i_trig;
    logic             i_abort;
    logic [CNT_W-1:0] i_cfg_delay;
    logic [CNT_W-1:0] i_cfg_len;
    logic [DEC_W-1:0] i_cfg_decim;
    logic [ADC_W-1:0] i_adc_data;
    logic             i_adc_vld;
    logic             i_fifo_afull;
    logic [ADC_W-1:0] o_pack_data;
    logic             o_pack_vld;
    logic             o_busy;
    logic             o_done;
    logic             o_ovf;

    adc_acq_ctrl #(
        .ADC_W (ADC_W),
        .CNT_W (CNT_W),
        .DEC_W (DEC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_trig       (i_trig),
        .i_abort      (i_abort),
        .i_cfg_delay  (i_cfg_delay),
        .i_cfg_len    (i_cfg_len),
        .i_cfg_decim  (i_cfg_decim),
        .i_adc_data   (i_adc_data),
        .i_adc_vld    (i_adc_vld),
        .i_fifo_afull (i_fifo_afull),
        .o_pack_data  (o_pack_data),
        .o_pack_vld   (o_pack_vld),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_ovf        (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // stimulus for one capture; trigger always at cycle 0
    bit               s_vld[N];
    logic [ADC_W-1:0] s_dat[N];
    bit               s_afull[N];
    int               c_delay, c_len, c_decim;
    int               ab_c, trig2_c;

    // expected per-cycle outputs
    bit               e_vld[N];
    logic [ADC_W-1:0] e_dat[N];
    bit               e_done[N];
    bit               e_busy[N];
    bit               e_ovf[N];
    int               done_c;
    int               m_drop_c;
    bit               prev_ovf;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stim();
        for (int t = 0; t < N; t++) begin
            s_vld[t]   = 0;
            s_dat[t]   = '0;
            s_afull[t] = 0;
        end
        ab_c    = -1;
        trig2_c = -1;
    endtask

    // Event-level model: count strobes after the trigger, skip `delay`,
    // keep every (decim+1)-th, stop at len kept or abort, then pad to 3.
    task automatic build_expect(output int end_c);
        int strobes, k, fwd, pad, m, idx;
        bit aborted;
        strobes  = 0;
        k        = 0;
        fwd      = 0;
        aborted  = 0;
        end_c    = -1;
        m_drop_c = N;
        for (int t = 0; t < N; t++) begin
            e_vld[t]  = 0;
            e_dat[t]  = '0;
            e_done[t] = 0;
            e_busy[t] = 0;
        end
        if (c_len == 0) begin
            done_c = 1;
        end else begin
            for (int c = 1; c < N - 1 && end_c < 0; c++) begin
                if (c == ab_c) begin
                    end_c   = c;
                    aborted = 1;
                end else if (s_vld[c]) begin
                    strobes++;
                    m = strobes - c_delay;
                    if (m > 0 && m % (c_decim + 1) == 0) begin
                        k++;
                        if (s_afull[c]) begin
                            if (m_drop_c == N) m_drop_c = c;
                        end else begin
                            e_vld[c+1] = 1;
`ifdef ACQ_TESTPAT_EN
                            e_dat[c+1] = ADC_W'(k - 1);
`else
                            e_dat[c+1] = s_dat[c];
`endif
                            fwd++;
                        end
                        if (k == c_len) end_c = c;
                    end
                end
            end
            if (end_c < 0) begin
                done_c = N;
            end else begin
                pad = (3 - fwd % 3) % 3;
                for (int p = 0; p < pad; p++) begin
                    idx = end_c + 2 + p;
                    if (idx < N) begin
                        e_vld[idx] = 1;
                        e_dat[idx] = '0;
                    end
                end
                done_c = (aborted && pad == 0) ? end_c + 2
                                               : end_c + pad + 1;
            end
        end
        if (done_c < N) e_done[done_c] = 1;
        if (c_len != 0)
            for (int t = 1; t < done_c && t < N; t++) e_busy[t] = 1;
        for (int t = 0; t < N; t++)
            e_ovf[t] = (t == 0) ? prev_ovf : (m_drop_c < t);
    endtask

    task automatic run_case(input string name);
        int e;
        build_expect(e);
        check($sformatf("%s budget", name), done_c < N - 2, 1);
        for (int t = 0; t < N; t++) begin
            @(posedge clk);
            #1;
            i_trig       = (t == 0) || (t == trig2_c);
            i_abort      = (t == ab_c);
            i_adc_vld    = s_vld[t];
            i_adc_data   = s_dat[t];
            i_fifo_afull = s_afull[t];
            if (t == 0) begin
                i_cfg_delay = CNT_W'(c_delay);
                i_cfg_len   = CNT_W'(c_len);
                i_cfg_decim = DEC_W'(c_decim);
            end else begin
                i_cfg_delay = CNT_W'($urandom);
                i_cfg_len   = CNT_W'($urandom);
                i_cfg_decim = DEC_W'($urandom);
            end
            @(negedge clk);
            check($sformatf("%s vld@%0d", name, t), o_pack_vld, e_vld[t]);
            if (e_vld[t])
                check($sformatf("%s data@%0d", name, t), o_pack_data,
                      e_dat[t]);
            check($sformatf("%s done@%0d", name, t), o_done, e_done[t]);
            check($sformatf("%s busy@%0d", name, t), o_busy, e_busy[t]);
            check($sformatf("%s ovf@%0d", name, t), o_ovf, e_ovf[t]);
        end
        prev_ovf = (m_drop_c < N);
        @(posedge clk);
        #1;
        i_trig       = 0;
        i_abort      = 0;
        i_adc_vld    = 0;
        i_fifo_afull = 0;
    endtask

    task automatic rand_case(input int idx);
        int pct, apct, e;
        clear_stim();
        c_delay = $urandom_range(0, 5);
        c_len   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
        c_decim = $urandom_range(0, 3);
        pct     = $urandom_range(50, 100);
        apct    = $urandom_range(0, 30);
        for (int t = 0; t < N; t++) begin
            s_vld[t]   = (t >= 200) || ($urandom_range(1, 100) <= pct);
            s_dat[t]   = ADC_W'($urandom);
            s_afull[t] = ($urandom_range(1, 100) <= apct);
        end
        build_expect(e);
        if ($urandom_range(0, 2) == 0)
            ab_c = (e > 0) ? $urandom_range(1, e + 4) : $urandom_range(1, 3);
        build_expect(e);
        if ($urandom_range(0, 1) == 0 && done_c < N)
            trig2_c = $urandom_range(1, done_c);
        run_case($sformatf("rnd%0d", idx));
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        prev_ovf     = 0;
        rst          = 1;
        i_trig       = 0;
        i_abort      = 0;
        i_cfg_delay  = '0;
        i_cfg_len    = '0;
        i_cfg_decim  = '0;
        i_adc_data   = '0;
        i_adc_vld    = 0;
        i_fifo_afull = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst vld", o_pack_vld, 0);
        check("rst data", o_pack_data, 0);
        check("rst busy", o_busy, 0);
        check("rst done", o_done, 0);
        check("rst ovf", o_ovf, 0);
        @(posedge clk);
        #1 rst = 0;

        // delay 0, len 6, keep all, 8 strobes
        clear_stim();
        c_delay = 0; c_len = 6; c_decim = 0;
        for (int t = 1; t <= 8; t++) begin
            s_vld[t] = 1;
            s_dat[t] = ADC_W'($urandom);
        end
        run_case("d0l6");

        // delay 2, len 4, decim 1, data 1..20 from the trigger cycle
        clear_stim();
        c_delay = 2; c_len = 4; c_decim = 1;
        for (int t = 0; t < 20; t++) begin
            s_vld[t] = 1;
            s_dat[t] = ADC_W'(t + 1);
        end
        run_case("d2l4");

        // len 3 with afull on the second kept sample
        clear_stim();
        c_delay = 0; c_len = 3; c_decim = 0;
        for (int t = 1; t <= 6; t++) begin
            s_vld[t] = 1;
            s_dat[t] = ADC_W'($urandom);
        end
        s_afull[2] = 1;
        run_case("afull");

        // abort after 4 kept of len 10, stray trigger while busy
        clear_stim();
        c_delay = 0; c_len = 10; c_decim = 0;
        for (int t = 1; t < 30; t++) begin
            s_vld[t] = 1;
            s_dat[t] = ADC_W'($urandom);
        end
        ab_c    = 5;
        trig2_c = 3;
        run_case("abort");

        // len 0
        clear_stim();
        c_delay = 3; c_len = 0; c_decim = 2;
        for (int t = 0; t < 10; t++) s_vld[t] = 1;
        run_case("len0");

        // reset in the middle of a capture
        @(posedge clk);
        #1;
        i_trig      = 1;
        i_cfg_delay = '0;
        i_cfg_len   = CNT_W'(10);
        i_cfg_decim = '0;
        i_adc_vld   = 1;
        i_adc_data  = ADC_W'(10'h155);
        @(posedge clk);
        #1 i_trig = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pre-rst busy", o_busy, 1);
        check("pre-rst vld", o_pack_vld, 1);
        #1 rst = 1;
        @(posedge clk);
        @(negedge clk);
        check("mid-rst vld", o_pack_vld, 0);
        check("mid-rst data", o_pack_data, 0);
        check("mid-rst busy", o_busy, 0);
        check("mid-rst done", o_done, 0);
        check("mid-rst ovf", o_ovf, 0);
        #1;
        rst       = 0;
        i_adc_vld = 0;
        prev_ovf  = 0;

        for (int i = 0; i < 25; i++) rand_case(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
